fib_job_scheduler: RTL and testbench

FIB_JOB_SCHEDULER -- requirements
Module: fib_job_scheduler

---
 rtl/fib_job_scheduler.sv | 113 +++++++++++
 tb/tb_fib_job_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fib_job_scheduler.sv
// fib_job_scheduler: round-robin front end that serialises requester jobs onto one Fibonacci generator
module fib_job_scheduler #(
   parameter int DATA_WIDTH    = 64,
   parameter int ORDER_WIDTH   = 16,
   parameter int NUM_REQ       = 4,
   parameter int TIMEOUT_SLACK = 4,
   localparam int IDW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   input  logic [NUM_REQ*ORDER_WIDTH-1:0] req_order,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           gen_reset_n,
   output logic                           gen_load,
   output logic [DATA_WIDTH-1:0]          gen_data_in,
   output logic [ORDER_WIDTH-1:0]         gen_order,
   input  logic                           gen_done,
   input  logic                           gen_overflow,
   input  logic                           gen_error,
   input  logic [DATA_WIDTH-1:0]          gen_data_out,
   output logic                           rsp_valid,
   output logic [IDW-1:0]                 rsp_id,
   output logic [DATA_WIDTH-1:0]          rsp_data,
   output logic [1:0]                     rsp_status,
   output logic                           busy
);
   localparam int CW = ORDER_WIDTH + 4;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT, FLUSH, RESP} state_t;
   state_t state;
   logic [IDW-1:0] last_grant, win, j;
   logic [CW-1:0] cnt, limit;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [ORDER_WIDTH-1:0] sel_order;
   // scan from last_grant+1 downward in priority so the nearest valid requester wins
   always_comb begin
      win = '0;
      j = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = IDW'((int'(last_grant) + 1 + k) % NUM_REQ);
         if (req_valid[j]) win = j;
      end
   end
   assign sel_data  = req_data[win*DATA_WIDTH +: DATA_WIDTH];
   assign sel_order = req_order[win*ORDER_WIDTH +: ORDER_WIDTH];
   assign req_ready = (state == IDLE && !reset) ? NUM_REQ'(|req_valid) << win : '0;
   assign busy      = state != IDLE;
   assign limit     = CW'(gen_order) + CW'(2 + TIMEOUT_SLACK);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= IDW'(NUM_REQ - 1);
         cnt         <= '0;
         gen_reset_n <= 1'b0;
         gen_load    <= 1'b0;
         gen_data_in <= '0;
         gen_order   <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_data    <= '0;
         rsp_status  <= '0;
      end else begin
         gen_reset_n <= 1'b1;
         gen_load    <= 1'b0;
         rsp_valid   <= 1'b0;
         case (state)
            IDLE: if (|req_valid) begin
               gen_data_in <= sel_data;
               gen_order   <= sel_order;
               rsp_id      <= win;
               rsp_data    <= '0;
               rsp_status  <= 2'b00;
               state       <= sel_order != '0 ? LOAD : RESP;
               gen_load    <= sel_order != '0;
               rsp_valid   <= sel_order == '0;
            end
            LOAD: begin
               cnt   <= CW'(1);
               state <= WAIT;
            end
            // a flag in the limit cycle still beats the timeout
            WAIT: if (gen_done || gen_overflow || gen_error) begin
               rsp_data   <= gen_data_out;
               rsp_status <= gen_error ? 2'b10 : gen_overflow ? 2'b01 : 2'b00;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end else if (cnt >= limit) begin
               gen_reset_n <= 1'b0;
               state       <= FLUSH;
            end else begin
               cnt <= cnt + 1'b1;
            end
            FLUSH: begin
               rsp_data   <= '0;
               rsp_status <= 2'b11;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               last_grant  <= rsp_id;
               gen_data_in <= '0;
               gen_order   <= '0;
               rsp_id      <= '0;
               rsp_data    <= '0;
               rsp_status  <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fib_job_scheduler.sv
// tb_fib_job_scheduler: randomized job traffic against a cycle-offset model of the scheduler
module tb_fib_job_scheduler;
   localparam int DW = 64, OW = 16, N = 4, IDW = 2;
   logic clk = 0, reset;
   logic [N-1:0] req_valid, req_ready;
   logic [N*DW-1:0] req_data;
   logic [N*OW-1:0] req_order;
   logic gen_reset_n, gen_load, gen_done, gen_overflow, gen_error, rsp_valid, busy;
   logic [DW-1:0] gen_data_in, gen_data_out, rsp_data;
   logic [OW-1:0] gen_order;
   logic [IDW-1:0] rsp_id;
   logic [1:0] rsp_status;
   int checks = 0, errors = 0, lg = N - 1;
   logic [DW-1:0] dat [N];
   logic [OW-1:0] ord [N];

   fib_job_scheduler dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_order(req_order),
      .req_ready(req_ready), .gen_reset_n(gen_reset_n), .gen_load(gen_load), .gen_data_in(gen_data_in),
      .gen_order(gen_order), .gen_done(gen_done), .gen_overflow(gen_overflow), .gen_error(gen_error),
      .gen_data_out(gen_data_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_status(rsp_status), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic int pick(input logic [N-1:0] m);
      for (int k = 1; k <= N; k++) if (m[(lg + k) % N]) return (lg + k) % N;
      return 0;
   endfunction

   task automatic drive(input logic [N-1:0] mask);
      req_valid = mask;
      for (int i = 0; i < N; i++) begin
         req_data[i*DW +: DW]  = dat[i];
         req_order[i*OW +: OW] = ord[i];
      end
   endtask

   // one job from the IDLE cycle of acceptance (c=0) to its response; d is the flag offset after LOAD
   task automatic run_job(input logic [N-1:0] mask, input int d, input logic [2:0] fl, input logic [DW-1:0] gout);
      int w, lim, rsp_c, flush_c;
      logic [1:0] es;
      logic [DW-1:0] ed, x;
      logic [OW-1:0] o;
      w = pick(mask); o = ord[w]; x = dat[w]; lim = int'(o) + 6; flush_c = -1;
      if (o == 0) begin rsp_c = 1; es = 2'd0; ed = '0; end
      else if (d <= lim) begin rsp_c = d + 2; es = fl[2] ? 2'd2 : fl[1] ? 2'd1 : 2'd0; ed = gout; end
      else begin flush_c = lim + 2; rsp_c = lim + 3; es = 2'd3; ed = '0; end
      for (int c = 0; c <= rsp_c; c++) begin
         @(negedge clk);
         if (c == 0) drive(mask);
         {gen_error, gen_overflow, gen_done} = (o != 0 && c == d + 1) ? fl :
            (c <= 1 || c == flush_c || c == rsp_c) ? 3'($urandom) : 3'b0;
         gen_data_out = (o != 0 && c == d + 1) ? gout : {$urandom, $urandom};
         #1;
         checks++;
         if (req_ready !== (c == 0 ? N'(1) << w : N'(0)))
            begin errors++; $display("FAIL req_ready c=%0d got %b want %b", c, req_ready, c == 0 ? N'(1) << w : N'(0)); end
         checks++;
         if (busy !== (c != 0)) begin errors++; $display("FAIL busy c=%0d got %b want %b", c, busy, c != 0); end
         checks++;
         if (gen_load !== (o != 0 && c == 1))
            begin errors++; $display("FAIL gen_load c=%0d got %b want %b", c, gen_load, o != 0 && c == 1); end
         checks++;
         if (gen_reset_n !== (c != flush_c))
            begin errors++; $display("FAIL gen_reset_n c=%0d got %b want %b", c, gen_reset_n, c != flush_c); end
         checks++;
         if (rsp_valid !== (c == rsp_c))
            begin errors++; $display("FAIL rsp_valid c=%0d got %b want %b", c, rsp_valid, c == rsp_c); end
         if (c == 0 || o != 0) begin
            checks++;
            if ({gen_data_in, gen_order} !== (c == 0 ? {DW'(0), OW'(0)} : {x, o}))
               begin errors++; $display("FAIL gen_operands c=%0d got %h/%0d want %h/%0d", c, gen_data_in, gen_order, c == 0 ? DW'(0) : x, c == 0 ? OW'(0) : o); end
         end
         if (c == rsp_c) begin
            checks++;
            if ({rsp_id, rsp_status, rsp_data} !== {IDW'(w), es, ed})
               begin errors++; $display("FAIL rsp id/status/data got %0d/%0d/%0d want %0d/%0d/%0d", rsp_id, rsp_status, rsp_data, w, es, ed); end
         end
      end
      lg = w;
   endtask

   task automatic test_reset;
      @(negedge clk);
      req_valid = '1;
      #1;
      checks++;
      if ({gen_reset_n, gen_load, rsp_valid, busy, req_ready} !== '0)
         begin errors++; $display("FAIL reset_ctrl got %b want 0", {gen_reset_n, gen_load, rsp_valid, busy, req_ready}); end
      checks++;
      if ({gen_data_in, gen_order, rsp_id, rsp_data, rsp_status} !== '0)
         begin errors++; $display("FAIL reset_data got %h want 0", {gen_data_in, gen_order, rsp_data}); end
      req_valid = '0;
      reset = 0;
      #1;
      checks++;
      if (gen_reset_n !== 1'b0) begin errors++; $display("FAIL gen_reset_n_pre_clk got %b want 0", gen_reset_n); end
      @(negedge clk);
      checks++;
      if (gen_reset_n !== 1'b1) begin errors++; $display("FAIL gen_reset_n_post_clk got %b want 1", gen_reset_n); end
      lg = N - 1;
   endtask

   task automatic test_back_to_back;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < N; i++) begin dat[i] = {$urandom, $urandom}; ord[i] = OW'($urandom_range(1, 8)); end
         run_job('1, $urandom_range(1, 6), 3'b001, {$urandom, $urandom});
      end
   endtask

   task automatic test_directed;
      dat[0] = 1; ord[0] = 10;
      run_job(4'b0001, 12, 3'b001, 64'd89);
   endtask

   task automatic test_zero_order;
      dat[2] = {$urandom, $urandom}; ord[2] = 0;
      run_job(4'b0100, 3, 3'b001, {$urandom, $urandom});
   endtask

   task automatic test_flags;
      ord[1] = 5;
      run_job(4'b0010, 3, 3'b110, {$urandom, $urandom});
      ord[3] = 7;
      run_job(4'b1000, 13, 3'b001, {$urandom, $urandom});
   endtask

   task automatic test_timeout;
      dat[0] = {$urandom, $urandom}; ord[0] = 3;
      run_job(4'b0001, 1000, 3'b001, {$urandom, $urandom});
   endtask

   task automatic test_reset_mid;
      ord[2] = 10;
      @(negedge clk);
      drive(4'b0100);
      repeat (4) @(negedge clk);
      req_valid = '0;
      #1 reset = 1;
      #1;
      checks++;
      if ({gen_reset_n, gen_load, rsp_valid, busy, req_ready, gen_data_in, gen_order} !== '0)
         begin errors++; $display("FAIL mid_reset_outputs got %h want 0", {gen_reset_n, gen_load, rsp_valid, busy, gen_data_in}); end
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mid_reset_quiet got %b want 00", {rsp_valid, busy}); end
      end
      lg = N - 1;
      for (int i = 0; i < N; i++) ord[i] = OW'($urandom_range(1, 6));
      run_job('1, 2, 3'b010, {$urandom, $urandom});
   endtask

   task automatic test_random;
      for (int j = 0; j < 40; j++) begin
         for (int i = 0; i < N; i++) begin
            dat[i] = {$urandom, $urandom};
            ord[i] = $urandom_range(0, 3) == 0 ? OW'(0) : OW'($urandom_range(1, 12));
         end
         run_job(N'($urandom_range(1, 15)), $urandom_range(1, 20), 3'($urandom_range(1, 7)), {$urandom, $urandom});
      end
   endtask

   initial begin
      reset = 1; req_valid = '0; req_data = '0; req_order = '0;
      gen_done = 0; gen_overflow = 0; gen_error = 0; gen_data_out = '0;
      for (int i = 0; i < N; i++) begin dat[i] = '0; ord[i] = '0; end
      repeat (2) @(posedge clk);
      test_reset;
      test_back_to_back;
      test_directed;
      test_zero_order;
      test_flags;
      test_timeout;
      test_reset_mid;
      test_random;
      @(negedge clk);
      req_valid = '0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
